fir_out_quantizer: RTL and testbench

//  Downstream stage of the 12-bit-in / 29-bit-out multiplierless FIR filter.
//  - Realigns a sample-valid strobe with the filter's fixed pipeline latency.
//  - Rounds and saturates the 29-bit filter output to a 16-bit sample.
//  - Buffers results in a small FIFO behind a ready/valid handshake to the consumer.
//  - Counts saturation events and dropped samples.

---
 rtl/fir_out_quantizer_if.sv | 22 ++
 rtl/fir_out_quantizer.sv | 129 ++++++++++++
 tb/tb_fir_out_quantizer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fir_out_quantizer_if.sv
// Ready/valid bundle between the FIR output quantizer and its neighbours.
// The master drives the filter side and consumes samples; the slave is the quantizer.
interface fir_out_quantizer_if #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  fir_y;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, fir_y, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, fir_y, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_out_quantizer.sv
// Realigns the FIR valid strobe, rounds/saturates the 29-bit result to 16 bits and
// buffers it in a small FIFO behind a ready/valid handshake, counting saturations and drops.
module fir_out_quantizer #(
  parameter int IN_W    = 29,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 13,
  parameter int LATENCY = 16,
  parameter int FIFO_D  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_out_quantizer_if.slave  bus,
  output logic [15:0]         sat_count,
  output logic [15:0]         drop_count,
  output logic                fifo_full
);

  localparam int PTR_W = $clog2(FIFO_D);

  localparam logic signed [IN_W:0] RND_C =
    {{(IN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_C =
    {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_C =
    {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_D);
  localparam logic [PTR_W:0]   OCC_ONE_C = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);
  localparam logic [15:0]      CNT_MAX_C = 16'hFFFF;

  logic [LATENCY-1:0]      r_vld;
  logic                    r_s1_vld;
  logic signed [IN_W:0]    r_s1;
  logic                    r_s2_vld;
  logic [OUT_W-1:0]        r_s2;
  logic [OUT_W-1:0]        r_mem [FIFO_D];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_occ;
  logic [15:0]             r_sat_cnt;
  logic [15:0]             r_drop_cnt;

  logic signed [IN_W:0]    w_ext;
  logic signed [IN_W:0]    w_sum;
  logic signed [IN_W:0]    w_rnd;
  logic [OUT_W-1:0]        w_q;
  logic                    w_sat;
  logic                    w_not_empty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  assign w_ext = $signed({bus.fir_y[IN_W-1], bus.fir_y});
  assign w_sum = w_ext + RND_C;
  assign w_rnd = w_sum >>> SHIFT;

  // Clamp the rounded value into the signed output range.
  always_comb begin
    w_sat = 1'b0;
    w_q   = r_s1[OUT_W-1:0];
    if (r_s1 > MAX_C) begin
      w_sat = 1'b1;
      w_q   = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (r_s1 < MIN_C) begin
      w_sat = 1'b1;
      w_q   = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_q   = r_s1[OUT_W-1:0];
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_not_empty = (r_occ != '0);
  assign w_pop       = w_not_empty && bus.out_ready;
  assign w_push      = r_s2_vld && ((r_occ < DEPTH_C) || w_pop);
  assign w_drop      = r_s2_vld && !w_push;

  // Valid alignment, rounding and saturation pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      r_s2_vld <= 1'b0;
      r_s2     <= '0;
    end else begin
      r_vld    <= {r_vld[LATENCY-2:0], bus.in_valid};
      r_s1_vld <= r_vld[LATENCY-1];
      if (r_vld[LATENCY-1]) r_s1 <= w_rnd;
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2 <= w_q;
    end
  end

  // FIFO storage; contents are qualified by occupancy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s2;
  end

  // FIFO pointers, occupancy and sticky event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_sat_cnt  <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE_C;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE_C;
        2'b01:   r_occ <= r_occ - OCC_ONE_C;
        default: r_occ <= r_occ;
      endcase
      if (r_s1_vld && w_sat && (r_sat_cnt != CNT_MAX_C))
        r_sat_cnt <= r_sat_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != CNT_MAX_C))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.out_valid = w_not_empty;
  assign bus.out_data  = w_not_empty ? $signed(r_mem[r_rd_ptr]) : '0;
  assign fifo_full     = (r_occ == DEPTH_C);
  assign sat_count     = r_sat_cnt;
  assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed bench for fir_out_quantizer: stimulus pushes expected samples into a queue,
// an independent monitor pops and compares whenever the DUT offers a sample.
module tb_fir_out_quantizer;
  localparam int LAT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sat_count;
  logic [15:0] drop_count;
  logic        fifo_full;

  fir_out_quantizer_if bus ();

  fir_out_quantizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sat_count  (sat_count),
    .drop_count (drop_count),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [15:0] exp_q [$];
  logic [28:0] sched [int];

  // Filter model: present each scheduled value LAT cycles after its strobe, junk otherwise.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (sched.exists(cyc)) bus.fir_y = sched[cyc];
    else bus.fir_y = 29'h0ABC_DEF1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: head must match while offered; popped on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", bus.out_data);
      end else begin
        if (bus.out_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", bus.out_data, exp_q[0]);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [28:0] val, input logic [15:0] exp, input bit push);
    bus.in_valid = 1'b1;
    sched[cyc + LAT] = val;
    if (push) exp_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.fir_y     = 29'h0;
    rst_n         = 1'b0;
    ticks(3);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_sat", {16'd0, sat_count}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // 1: first-result latency and basic rounding
    k = cyc;
    send(29'h0000_1000, 16'h0001, 1'b1);
    for (int i = 0; i < LAT + 10 && bus.out_valid !== 1'b1; i++) tick();
    chk("latency", cyc - k, LAT + 3);
    ticks(4);

    // 2: round half toward +inf around zero
    send(29'h1FFF_F000, 16'h0000, 1'b1);
    send(29'h1FFF_EFFF, 16'hFFFF, 1'b1);
    send(29'h0000_0FFF, 16'h0000, 1'b1);
    ticks(LAT + 6);
    chk("t2_sat", {16'd0, sat_count}, 32'd0);
    chk("t2_drained", exp_q.size(), 32'd0);

    // 3: positive overflow saturates; most-negative input rounds exactly to the minimum
    send(29'h0FFF_FFFF, 16'h7FFF, 1'b1);
    ticks(LAT + 6);
    chk("t3_sat_pos", {16'd0, sat_count}, 32'd1);
    send(29'h1000_0000, 16'h8000, 1'b1);
    ticks(LAT + 6);
    chk("t3_sat_neg", {16'd0, sat_count}, 32'd1);

    // 4: stalled consumer, six samples into a four-deep FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(29'((10 + i) * 8192), 16'(10 + i), (i < 4));
    ticks(LAT + 6);
    chk("t4_full", {31'd0, fifo_full}, 32'd1);
    chk("t4_drop", {16'd0, drop_count}, 32'd2);
    bus.out_ready = 1'b1;
    ticks(6);
    chk("t4_drained", exp_q.size(), 32'd0);
    chk("t4_empty", {31'd0, bus.out_valid}, 32'd0);

    // 5: write into a full FIFO on the same edge as a pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(29'((20 + i) * 8192), 16'(20 + i), 1'b1);
    ticks(LAT + 6);
    chk("t5_full_before", {31'd0, fifo_full}, 32'd1);
    k = cyc;
    send(29'(24 * 8192), 16'd24, 1'b1);
    ticks(k + LAT + 2 - cyc);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t5_full_after", {31'd0, fifo_full}, 32'd1);
    chk("t5_drop", {16'd0, drop_count}, 32'd2);
    ticks(3);
    chk("t5_pending", exp_q.size(), 32'd4);
    bus.out_ready = 1'b1;
    ticks(6);
    chk("t5_drained", exp_q.size(), 32'd0);

    // 6: reset with buffered and in-flight samples
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(29'((30 + i) * 8192), 16'(30 + i), 1'b1);
    ticks(LAT + 5);
    chk("t6_buffered", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++)
      send(29'((40 + i) * 8192), 16'(40 + i), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    chk("t6_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_data", {16'd0, bus.out_data}, 32'd0);
    chk("t6_full", {31'd0, fifo_full}, 32'd0);
    chk("t6_sat", {16'd0, sat_count}, 32'd0);
    chk("t6_drop", {16'd0, drop_count}, 32'd0);
    k = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (bus.out_valid === 1'b1) k++;
      tick();
    end
    chk("t6_silent", k, 32'd0);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
